mat_cache_ctrl: RTL
===================

// Module: mat_cache_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the matrix row cache. Shares the cache between a
//  write requester (DMA loader) and a read requester (matrix compute unit). Each
//  request is a burst of consecutive rows. Controller generates row addresses,
//  drives cache mode/addresses/write data and returns read rows with valid/ready.
// PARAMETERS
//  WIDTH      128                     shortreal elements per cache row
//  CACHESIZE  256                     rows in cache
//  CACHEADDR  $clog2(CACHESIZE)       row address width
// PORTS
//  clock          in   1               single clock, rising edge
//  reset          in   1               asynchronous, active-high
//  wr_req_valid   in   1               write burst request
//  wr_req_ready   out  1               write burst accepted (IDLE + granted)
//  wr_base        in   CACHEADDR       first row of write burst
//  wr_len         in   CACHEADDR+1     rows in burst, 0..CACHESIZE
//  wr_beat_valid  in   1               write row present
//  wr_beat_ready  out  1               controller takes write row
//  wr_data        in   WIDTH shortreal write row
//  rd_req_valid   in   1               read burst request
//  rd_req_ready   out  1               read burst accepted
//  rd_base        in   CACHEADDR       first row of read burst
//  rd_len         in   CACHEADDR+1     rows in burst, 0..CACHESIZE
//  rd_beat_valid  out  1               read row present on rd_data
//  rd_beat_ready  in   1               consumer takes read row
//  rd_data        out  WIDTH shortreal read row (= cache_data_out)
//  rd_last        out  1               final beat of read burst
//  cache_mode     out  1               1 = write cache_data_in to mem[cache_addr1]
//  cache_addr1    out  CACHEADDR       write row address
//  cache_addr2    out  CACHEADDR       read row address
//  cache_data_in  out  WIDTH shortreal write row to cache (= wr_data)
//  cache_data_out in   WIDTH shortreal mem[cache_addr2 of previous cycle]
//  busy           out  1               state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE, ptr/cnt 0, last_grant=READ (write wins first tie);
//    all outputs 0. Reset mid-burst abandons it; rows already written stay.
//  - FSM IDLE/WR/RD. IDLE: one valid -> grant it; both -> grant opposite of
//    last_grant (round robin). req_ready high only for granted side, combinational.
//    Accept with len 0 = no-op, stay IDLE, last_grant updated.
//  - Accept: ptr<=base, cnt<=len, go WR or RD next cycle. No requests taken outside IDLE.
//  - WR: wr_beat_ready=1. Beat fires (valid&ready): cache_mode=1, cache_addr1=ptr,
//    cache_data_in=wr_data same cycle; ptr<=ptr+1 mod CACHESIZE; cnt<=cnt-1.
//    cnt==1 beat -> IDLE next cycle. No fire -> cache_mode=0.
//  - RD: first RD cycle primes: cache_addr2=ptr, rd_beat_valid=0. Later cycles:
//    rd_beat_valid=1, rd_data=cache_data_out, rd_last=(cnt==1). Fire: cache_addr2=
//    ptr+1 (mod), ptr/cnt advance; stalled: cache_addr2 held = ptr, so row is stable.
//    Last beat fire -> IDLE next cycle. Throughput 1 row/cycle; first row 2 cycles
//    after request accept.
//  - Reads and writes never overlap; cache_mode=0 in IDLE and RD.
//  - Wrap: address CACHESIZE-1 followed by 0. len=CACHESIZE covers whole cache once.
//  - busy=1 in WR/RD. Back-to-back bursts: one IDLE cycle between bursts.
// TESTING
//  1 Write base=4 len=3, rows 1.0/2.0/3.0 -> cache_mode=1 on 3 fires, addr1=4,5,6;
//    wr_beat_ready drops after 3rd; busy low next cycle.
//  2 Read base=4 len=3, ready=1 -> beats 2,3,4 cycles after accept: 1.0,2.0,3.0;
//    rd_last only on 3rd; cache_mode stays 0.
//  3 Same read, rd_beat_ready low 2 cycles on beat 2 -> rd_data holds 2.0,
//    cache_addr2 stays 5, no beat dropped or duplicated.
//  4 Write base=254 len=4 -> addr1 254,255,0,1; read back base=254 len=4 matches.
//  5 Both reqs valid from reset -> write granted, then read; repeat -> write again;
//    len=0 request -> accepted, no beats, busy stays 0.
//  6 Reset asserted after 2 of 4 write beats -> immediately cache_mode=0, busy=0,
//    all readies 0; after release new read request accepted normally.

Source files
------------

// File: rtl/mat_cache_ctrl_if.sv
// Requester/cache bundle for the matrix row cache controller.
// slave = controller side, master = requesters plus cache memory.
interface mat_cache_if #(
  parameter int WIDTH     = 128,
  parameter int CACHESIZE = 256
);
  localparam int AW = $clog2(CACHESIZE);

  logic                    wr_req_valid;
  logic                    wr_req_ready;
  logic [AW-1:0]           wr_base;
  logic [AW:0]             wr_len;
  logic                    wr_beat_valid;
  logic                    wr_beat_ready;
  logic [WIDTH-1:0][31:0]  wr_data;

  logic                    rd_req_valid;
  logic                    rd_req_ready;
  logic [AW-1:0]           rd_base;
  logic [AW:0]             rd_len;
  logic                    rd_beat_valid;
  logic                    rd_beat_ready;
  logic [WIDTH-1:0][31:0]  rd_data;
  logic                    rd_last;

  logic                    cache_mode;
  logic [AW-1:0]           cache_addr1;
  logic [AW-1:0]           cache_addr2;
  logic [WIDTH-1:0][31:0]  cache_data_in;
  logic [WIDTH-1:0][31:0]  cache_data_out;

  logic                    busy;

  modport slave (
    input  wr_req_valid, wr_base, wr_len,
    input  wr_beat_valid, wr_data,
    input  rd_req_valid, rd_base, rd_len,
    input  rd_beat_ready, cache_data_out,
    output wr_req_ready, wr_beat_ready,
    output rd_req_ready, rd_beat_valid,
    output rd_data, rd_last,
    output cache_mode, cache_addr1,
    output cache_addr2, cache_data_in,
    output busy
  );

  modport master (
    output wr_req_valid, wr_base, wr_len,
    output wr_beat_valid, wr_data,
    output rd_req_valid, rd_base, rd_len,
    output rd_beat_ready, cache_data_out,
    input  wr_req_ready, wr_beat_ready,
    input  rd_req_ready, rd_beat_valid,
    input  rd_data, rd_last,
    input  cache_mode, cache_addr1,
    input  cache_addr2, cache_data_in,
    input  busy
  );
endinterface

// File: rtl/mat_cache_ctrl.sv
// Burst sequencer sharing the matrix row cache between
// a DMA write requester and a compute read requester.
module mat_cache_ctrl #(
  parameter int WIDTH     = 128,
  parameter int CACHESIZE = 256
) (
  input logic      clock,
  input logic      reset,
  mat_cache_if.slave bus
);
  localparam int AW = $clog2(CACHESIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_ptr_inc;
  logic [AW:0]   r_cnt;
  logic [AW:0]   w_cnt_nxt;
  logic          r_last_wr;
  logic          w_last_wr_nxt;
  logic          r_prime;
  logic          w_prime_nxt;
  logic          w_grant_wr;
  logic          w_grant_rd;
  logic          w_cnt_one;

  assign w_ptr_inc = (r_ptr == AW'(CACHESIZE - 1))
                   ? '0 : r_ptr + 1'b1;
  assign w_cnt_one = (r_cnt == (AW+1)'(1));

  // Round robin: a tie goes to the side not served last
  assign w_grant_wr = bus.wr_req_valid
                    & (~bus.rd_req_valid | ~r_last_wr);
  assign w_grant_rd = bus.rd_req_valid
                    & (~bus.wr_req_valid | r_last_wr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_last_wr <= 1'b0;
      r_prime   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_prime   <= w_prime_nxt;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_last_wr_nxt     = r_last_wr;
    w_prime_nxt       = r_prime;
    bus.wr_req_ready  = 1'b0;
    bus.rd_req_ready  = 1'b0;
    bus.wr_beat_ready = 1'b0;
    bus.rd_beat_valid = 1'b0;
    bus.rd_last       = 1'b0;
    bus.rd_data       = '0;
    bus.cache_mode    = 1'b0;
    bus.cache_addr1   = r_ptr;
    bus.cache_addr2   = r_ptr;
    bus.cache_data_in = '0;
    bus.busy          = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        bus.wr_req_ready = w_grant_wr;
        bus.rd_req_ready = w_grant_rd;
        if (w_grant_wr) begin
          w_last_wr_nxt = 1'b1;
          w_ptr_nxt     = bus.wr_base;
          w_cnt_nxt     = bus.wr_len;
          if (bus.wr_len != '0) w_next = S_WR;
        end else if (w_grant_rd) begin
          w_last_wr_nxt = 1'b0;
          w_ptr_nxt     = bus.rd_base;
          w_cnt_nxt     = bus.rd_len;
          w_prime_nxt   = 1'b1;
          if (bus.rd_len != '0) w_next = S_RD;
        end
      end
      S_WR: begin
        bus.wr_beat_ready = 1'b1;
        bus.cache_data_in = bus.wr_data;
        if (bus.wr_beat_valid) begin
          bus.cache_mode = 1'b1;
          w_ptr_nxt      = w_ptr_inc;
          w_cnt_nxt      = r_cnt - 1'b1;
          if (w_cnt_one) w_next = S_IDLE;
        end
      end
      S_RD: begin
        bus.rd_data = bus.cache_data_out;
        // First cycle only presents the address
        if (r_prime) begin
          w_prime_nxt = 1'b0;
        end else begin
          bus.rd_beat_valid = 1'b1;
          bus.rd_last       = w_cnt_one;
          if (bus.rd_beat_ready) begin
            bus.cache_addr2 = w_ptr_inc;
            w_ptr_nxt       = w_ptr_inc;
            w_cnt_nxt       = r_cnt - 1'b1;
            if (w_cnt_one) w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
